// File: rtl/pixclk_ce_gen_if.sv
// Mode-request and clock-enable bundle between pixclk_ce_gen and its CRTC-side consumer.
// The master is the consumer: it issues mode requests and receives the enables.
interface pixclk_ce_gen_if;
    logic mode_req;
    logic mode_sel;
    logic pix_ce;
    logic char_ce;
    logic cur_mode;
    logic mode_ack;
    logic locked;

    modport master (
        output mode_req,
        output mode_sel,
        input  pix_ce,
        input  char_ce,
        input  cur_mode,
        input  mode_ack,
        input  locked
    );

    modport slave (
        input  mode_req,
        input  mode_sel,
        output pix_ce,
        output char_ce,
        output cur_mode,
        output mode_ack,
        output locked
    );
endinterface

// File: rtl/pixclk_ce_gen.sv
// Fractional pixel/character clock-enable generator driven by a phase accumulator.
// Two runtime-selectable video modes; mode changes take effect only at character boundaries.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// REQ_IDLE | no mode change waiting
// REQ_PEND | request stored in req_sel_q, applies at next char_ce
module pixclk_ce_gen #(
    parameter int unsigned ACC_W      = 24,
    parameter int unsigned INC0       = 24'd12032922,
    parameter int unsigned INC1       = 24'd10601144,
    parameter int unsigned CHAR_W0    = 9,
    parameter int unsigned CHAR_W1    = 8,
    parameter int unsigned LOCK_CNT   = 16,
    parameter bit          RESET_MODE = 1'b0
) (
    input  logic           clk,
    input  logic           rstb,
    pixclk_ce_gen_if.slave bus
);

    typedef enum logic {
        REQ_IDLE = 1'b0,
        REQ_PEND = 1'b1
    } req_state_t;

    localparam logic [ACC_W-1:0] INC0_C  = ACC_W'(INC0);
    localparam logic [ACC_W-1:0] INC1_C  = ACC_W'(INC1);
    localparam logic [3:0]       CW0_M1  = 4'(CHAR_W0 - 1);
    localparam logic [3:0]       CW1_M1  = 4'(CHAR_W1 - 1);
    localparam logic [7:0]       LOCK_C  = 8'(LOCK_CNT);

    req_state_t       state_q,    state_d;
    logic             req_sel_q,  req_sel_d;
    logic [ACC_W-1:0] acc_q,      acc_d;
    logic [3:0]       dot_q,      dot_d;
    logic [7:0]       lock_q,     lock_d;
    logic             cur_mode_q, cur_mode_d;
    logic             pix_ce_q,   pix_ce_d;
    logic             char_ce_q,  char_ce_d;
    logic             mode_ack_q, mode_ack_d;
    logic             locked_q,   locked_d;

    logic [ACC_W-1:0] inc_sel;
    logic [3:0]       cw_m1_sel;
    logic [ACC_W:0]   acc_sum;

    always_comb begin
        state_d    = state_q;
        req_sel_d  = req_sel_q;
        cur_mode_d = cur_mode_q;
        mode_ack_d = 1'b0;
        char_ce_d  = 1'b0;

        inc_sel   = cur_mode_q ? INC1_C : INC0_C;
        cw_m1_sel = cur_mode_q ? CW1_M1 : CW0_M1;

        acc_sum  = {1'b0, acc_q} + {1'b0, inc_sel};
        acc_d    = acc_sum[ACC_W-1:0];
        pix_ce_d = acc_sum[ACC_W];

        dot_d = dot_q;
        if (pix_ce_d) begin
            if (dot_q == cw_m1_sel) begin
                dot_d     = 4'd0;
                char_ce_d = 1'b1;
            end else begin
                dot_d = dot_q + 4'd1;
            end
        end

        // Counts the pulses already presented on pix_ce, so lock trails the last one by an edge.
        lock_d = lock_q;
        if (pix_ce_q && (lock_q < LOCK_C)) begin
            lock_d = lock_q + 8'd1;
        end

        case (state_q)
            REQ_IDLE: begin
                if (bus.mode_req) begin
                    state_d   = REQ_PEND;
                    req_sel_d = bus.mode_sel;
                end
            end
            REQ_PEND: begin
                if (char_ce_d) begin
                    cur_mode_d = req_sel_q;
                    acc_d      = '0;
                    dot_d      = 4'd0;
                    mode_ack_d = 1'b1;
                    if (req_sel_q != cur_mode_q) begin
                        lock_d = 8'd0;
                    end
                    // A request landing on the apply edge queues for the next boundary.
                    if (bus.mode_req) begin
                        state_d   = REQ_PEND;
                        req_sel_d = bus.mode_sel;
                    end else begin
                        state_d = REQ_IDLE;
                    end
                end else if (bus.mode_req) begin
                    req_sel_d = bus.mode_sel;
                end
            end
            default: begin
                state_d = REQ_IDLE;
            end
        endcase

        locked_d = (lock_d == LOCK_C);
    end

    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            state_q    <= REQ_IDLE;
            req_sel_q  <= 1'b0;
            acc_q      <= '0;
            dot_q      <= 4'd0;
            lock_q     <= 8'd0;
            cur_mode_q <= RESET_MODE;
            pix_ce_q   <= 1'b0;
            char_ce_q  <= 1'b0;
            mode_ack_q <= 1'b0;
            locked_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            req_sel_q  <= req_sel_d;
            acc_q      <= acc_d;
            dot_q      <= dot_d;
            lock_q     <= lock_d;
            cur_mode_q <= cur_mode_d;
            pix_ce_q   <= pix_ce_d;
            char_ce_q  <= char_ce_d;
            mode_ack_q <= mode_ack_d;
            locked_q   <= locked_d;
        end
    end

    assign bus.pix_ce   = pix_ce_q;
    assign bus.char_ce  = char_ce_q;
    assign bus.cur_mode = cur_mode_q;
    assign bus.mode_ack = mode_ack_q;
    assign bus.locked   = locked_q;

endmodule
